// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART receive/transmit blocks.
// State encodings, parity modes and a constant clog2 for counter sizing.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level; latency 2 clk, no backpressure.
// Reset value is a parameter so idle-high and idle-low lines can share it.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff_q <= {2{RST_VAL}};
    else       ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver (DBIT data, optional parity, SB_TICK stop); rx_done 1 clk after last stop tick, no backpressure.
// UART_RX_MAJORITY_EN selects 2-of-3 majority sampling instead of a single centre sample.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      par_mode,
  output logic            rx_done,
  output logic [DBIT-1:0] dout,
  output logic            par_err,
  output logic            frm_err
);

  // s must reach SB_TICK-1 in the stop phase, which may exceed OVS-1.
  localparam int SW = clog2(SB_TICK);
  localparam int NW = clog2(DBIT);
  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_SAMP = SW'(OVS - 1);
  localparam logic [SW-1:0] S_END  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_s;
  logic samp;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] maj_q, maj_d;

  assign maj_d = s_tick ? {maj_q[1:0], rx_s} : maj_q;
  assign samp  = (maj_d[0] & maj_d[1]) | (maj_d[0] & maj_d[2]) | (maj_d[1] & maj_d[2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) maj_q <= 3'b111;
    else       maj_q <= maj_d;
  end
`else
  assign samp = rx_s;
`endif

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0]      mode_q, mode_d;
  logic            perr_q, perr_d;
  logic            stop_q, stop_d;
  logic            armed_q, armed_d;
  logic            done_q, done_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            par_err_q, par_err_d;
  logic            frm_err_q, frm_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      mode_q    <= PAR_NONE;
      perr_q    <= 1'b0;
      stop_q    <= 1'b1;
      armed_q   <= 1'b1;
      done_q    <= 1'b0;
      dout_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      perr_q    <= perr_d;
      stop_q    <= stop_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    logic stop_now;
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    mode_d    = mode_q;
    perr_d    = perr_q;
    stop_d    = stop_q;
    armed_d   = armed_q;
    done_d    = 1'b0;
    dout_d    = dout_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    stop_now  = stop_q;

    // A held-low line must go high again before a new start is accepted.
    if (state_q == ST_IDLE || state_q == ST_STOP) armed_d = armed_q | rx_s;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s && armed_q) begin
          state_d = ST_START;
          s_d     = '0;
          mode_d  = par_mode;
          perr_d  = 1'b0;
          armed_d = 1'b0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_HALF) begin
            s_d = '0;
            n_d = '0;
            state_d = samp ? ST_IDLE : ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_SAMP) begin
            b_d = {samp, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) begin
              state_d = (mode_q == PAR_EVEN || mode_q == PAR_ODD) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_SAMP) begin
            perr_d  = samp ^ (^b_q) ^ (mode_q == PAR_ODD);
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_SAMP) begin
            stop_now = samp;
            stop_d   = samp;
          end
          if (s_q == S_END) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            dout_d    = b_q;
            par_err_d = perr_q;
            frm_err_d = ~stop_now;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_done = done_q;
  assign dout    = dout_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: an 8-bit/OVS16 instance and a 9-bit/OVS8/odd-parity instance.
module tb_uart_rx_ext;

  logic       clk, reset, s_tick;
  logic       rx_a, rx_b;
  logic [1:0] pm_a, pm_b;
  logic       rx_done_a, rx_done_b;
  logic [7:0] dout_a;
  logic [8:0] dout_b;
  logic       par_err_a, frm_err_a, par_err_b, frm_err_b;

  int n_chk = 0;
  int n_fail = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int exp_a = 0;
  int cyc = 0;
  int tick_cyc = 0;
  int gap_b = -1;
  logic [7:0] cap_dout_a;
  logic [8:0] cap_dout_b;
  logic       cap_pe_a, cap_fe_a, cap_pe_b, cap_fe_b;

  localparam int BCLK_A = 64;
  localparam int BCLK_B = 32;

  uart_rx_ext #(.DBIT(8), .OVS(16), .SB_TICK(16)) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx_a),
    .s_tick   (s_tick),
    .par_mode (pm_a),
    .rx_done  (rx_done_a),
    .dout     (dout_a),
    .par_err  (par_err_a),
    .frm_err  (frm_err_a)
  );

  uart_rx_ext #(.DBIT(9), .OVS(8), .SB_TICK(16)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx_b),
    .s_tick   (s_tick),
    .par_mode (pm_b),
    .rx_done  (rx_done_b),
    .dout     (dout_b),
    .par_err  (par_err_b),
    .frm_err  (frm_err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_tick) tick_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rx_done_a) begin
      cnt_a      <= cnt_a + 1;
      cap_dout_a <= dout_a;
      cap_pe_a   <= par_err_a;
      cap_fe_a   <= frm_err_a;
    end
    if (rx_done_b) begin
      cnt_b      <= cnt_b + 1;
      cap_dout_b <= dout_b;
      cap_pe_b   <= par_err_b;
      cap_fe_b   <= frm_err_b;
      gap_b      <= cyc - tick_cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit to_b, input logic v, input int clks);
    if (to_b) rx_b = v;
    else      rx_a = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send(input bit to_b, input logic [8:0] d, input int nb, input bit has_par,
                      input logic par, input logic stp, input int nstop, input int bclk);
    drive(to_b, 1'b0, bclk);
    for (int i = 0; i < nb; i++) drive(to_b, d[i], bclk);
    if (has_par) drive(to_b, par, bclk);
    for (int i = 0; i < nstop; i++) drive(to_b, stp, bclk);
    drive(to_b, 1'b1, bclk);
  endtask

  task automatic chk_frame_a(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    exp_a++;
    chk({tag, "_cnt"}, cnt_a, exp_a);
    chk({tag, "_dout"}, {24'd0, cap_dout_a}, {24'd0, d});
    chk({tag, "_par_err"}, {31'd0, cap_pe_a}, {31'd0, pe});
    chk({tag, "_frm_err"}, {31'd0, cap_fe_a}, {31'd0, fe});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    pm_a  = 2'd0;
    pm_b  = 2'd2;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, rx_done_a}, 32'd0);
    chk("rst_dout", {24'd0, dout_a}, 32'd0);
    chk("rst_par_err", {31'd0, par_err_a}, 32'd0);
    chk("rst_frm_err", {31'd0, frm_err_a}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 2 * BCLK_A);

    // no parity
    send(1'b0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1, BCLK_A);
    chk_frame_a("f55", 8'h55, 1'b0, 1'b0);
    send(1'b0, 9'h0A3, 8, 1'b0, 1'b0, 1'b1, 1, BCLK_A);
    chk_frame_a("fA3", 8'hA3, 1'b0, 1'b0);

    // even parity: 0x07 has three ones, so the correct bit is 1
    pm_a = 2'd1;
    send(1'b0, 9'h007, 8, 1'b1, 1'b0, 1'b1, 1, BCLK_A);
    chk_frame_a("even_bad", 8'h07, 1'b1, 1'b0);
    send(1'b0, 9'h007, 8, 1'b1, 1'b1, 1'b1, 1, BCLK_A);
    chk_frame_a("even_good", 8'h07, 1'b0, 1'b0);
    pm_a = 2'd0;

    // stop bit low, then recovery
    send(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1, BCLK_A);
    chk_frame_a("stop_low", 8'h3C, 1'b0, 1'b1);
    send(1'b0, 9'h012, 8, 1'b0, 1'b0, 1'b1, 1, BCLK_A);
    chk_frame_a("after_stop_low", 8'h12, 1'b0, 1'b0);

    // false start: low for 3 tick periods
    drive(1'b0, 1'b0, 12);
    drive(1'b0, 1'b1, 2 * BCLK_A);
    chk("false_start_cnt", cnt_a, exp_a);
    send(1'b0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1, BCLK_A);
    chk_frame_a("after_false", 8'h81, 1'b0, 1'b0);

    // reset in the middle of the fifth data bit
    drive(1'b0, 1'b0, BCLK_A);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, BCLK_A);
    drive(1'b0, 1'b1, BCLK_A / 2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_done", {31'd0, rx_done_a}, 32'd0);
    chk("midrst_dout", {24'd0, dout_a}, 32'd0);
    chk("midrst_frm_err", {31'd0, frm_err_a}, 32'd0);
    rx_a  = 1'b1;
    reset = 1'b0;
    drive(1'b0, 1'b1, 2 * BCLK_A);
    chk("midrst_cnt", cnt_a, exp_a);
    send(1'b0, 9'h0F0, 8, 1'b0, 1'b0, 1'b1, 1, BCLK_A);
    chk_frame_a("after_rst", 8'hF0, 1'b0, 1'b0);

    // break: one frame with framing error, no re-arm while low
    drive(1'b0, 1'b0, 14 * BCLK_A);
    drive(1'b0, 1'b1, 2 * BCLK_A);
    chk_frame_a("break", 8'h00, 1'b0, 1'b1);
    send(1'b0, 9'h0C5, 8, 1'b0, 1'b0, 1'b1, 1, BCLK_A);
    chk_frame_a("after_break", 8'hC5, 1'b0, 1'b0);

    // 9-bit, OVS 8, two stop bits' worth of ticks, odd parity (0x1AB has six ones)
    send(1'b1, 9'h1AB, 9, 1'b1, 1'b1, 1'b1, 2, BCLK_B);
    chk("b_cnt", cnt_b, 32'd1);
    chk("b_dout", {23'd0, cap_dout_b}, 32'h1AB);
    chk("b_par_err", {31'd0, cap_pe_b}, 32'd0);
    chk("b_frm_err", {31'd0, cap_fe_b}, 32'd0);
    chk("b_done_latency", gap_b, 32'd0);
    send(1'b1, 9'h1AB, 9, 1'b1, 1'b0, 1'b1, 2, BCLK_B);
    chk("b_bad_par_cnt", cnt_b, 32'd2);
    chk("b_bad_par_err", {31'd0, cap_pe_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
